// File: rtl/spi_pkg.sv
// Shared SPI definitions for the link transmitter and receiver.
// Holds the default word width, the receiver FSM state type and the
// SPI mode (CPOL=0, CPHA=0) that both ends of the link agree on.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Mode 0: SCK idles low, data sampled on the rising edge.
    localparam spi_mode_t SPI_MODE = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/spi_rx_slave_sync_bit.sv
// sync_bit: multi-flop synchronizer for one asynchronous input bit.
// Ports:
//   i_clk  - destination clock
//   i_rst  - asynchronous active-high reset, loads RST_VAL into every stage
//   i_d    - asynchronous input
//   o_q    - synchronized output (STAGES clk cycles of latency)
module sync_bit
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Synchronizer flop chain; reset loads the idle level of the line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_rx_slave.sv
// spi_rx_slave: SPI mode-0 receiver, oversampled in the local clock domain.
// Ports:
//   i_clk, i_rst          - system clock, asynchronous active-high reset
//   i_sck, i_cs_n, i_mosi - raw SPI pins (asynchronous to i_clk)
//   o_rx_data             - last accepted word (MSB received first)
//   o_rx_valid            - o_rx_data holds an unread word
//   i_rx_ready            - consumer takes the word when valid && ready
//   o_overrun             - sticky: a completed word was dropped
//   i_overrun_clr         - one-cycle pulse clearing o_overrun
//   o_busy                - a transfer is active
module spi_rx_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_overrun,
    input  logic              i_overrun_clr,
    output logic              o_busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic              w_sck_s;
    logic              w_cs_n_s;
    logic              w_mosi_s;
    logic              w_sck_rise;
    logic              w_shift;
    logic              r_sck_d;
    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_done;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_overrun;

    // All three lines share one depth so MOSI keeps its skew relative to SCK.
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (i_sck),  .o_q (w_sck_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (i_cs_n), .o_q (w_cs_n_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk (i_clk), .i_rst (i_rst), .i_d (i_mosi), .o_q (w_mosi_s)
    );

    assign w_sck_rise = w_sck_s & ~r_sck_d;
    // A rise only counts while selected; rises racing the deselect are dropped.
    assign w_shift    = (r_state == ACTIVE) && !w_cs_n_s && w_sck_rise;

    // FSM state register and delayed SCK sample for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sck_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sck_d <= w_sck_s;
        end
    end

    // FSM next state: chip select alone drives IDLE/ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_cs_n_s) begin
                    w_state_nxt = ACTIVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (w_cs_n_s) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bit counter and shift register; r_done pulses when a word completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == ACTIVE) && w_cs_n_s) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[DATA_W-2:0], w_mosi_s};
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    r_done    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output word register with valid/ready handshake and sticky overrun.
    // A completion in the same cycle as a handshake replaces the word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_done) begin
                if (!r_rx_valid || i_rx_ready) begin
                    r_rx_data  <= r_shreg;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (r_done && r_rx_valid && !i_rx_ready) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_overrun  = r_overrun;
    assign o_busy     = (r_state == ACTIVE);

endmodule

// File: doc/spi_rx_slave.md
# spi_rx_slave

SPI mode-0 receiver for the far end of the team's SPI link: it accepts the MSB-first byte stream driven by our shift-register transmitter, which changes data on SCK falling edges. The block oversamples SCK, CS_N and MOSI in the local system clock domain and samples MOSI on each synchronized SCK rising edge. It assembles DATA_W-bit words and presents each word on a valid/ready port with overrun detection. It sits between the SPI pins and the local register/FIFO logic.

## Interface
- DATA_W, 8, word width in bits; MSB received first.
- SYNC_STAGES, 2, synchronizer depth for sck, cs_n and mosi; minimum 2.
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst  in  1  reset, asynchronous, active-high.
- sck  in  1  SPI clock, idle low, asynchronous to clk.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data, stable around SCK rising edge.
- rx_data  out  DATA_W  last accepted word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- overrun  out  1  sticky flag: a completed word was dropped.
- overrun_clr  in  1  clears overrun, one-cycle pulse.
- busy  out  1  high while a transfer is active (state ACTIVE).

## Operation
- Synchronizers reset to idle levels: sck=0, cs_n=1, mosi=0. The edge detector compares the last two synchronized sck samples.
- FSM IDLE: bit counter = 0 and the shift register is held. Transition to ACTIVE when synced cs_n == 0.
- FSM ACTIVE: each sck rise shifts the register: shreg <= {shreg[DATA_W-2:0], mosi_s}, and bit_cnt increments.
  - When bit_cnt == DATA_W-1 on a rise, the word completes and bit_cnt wraps to 0. Stay in ACTIVE, so back-to-back words need no CS toggle.
  - Transition to IDLE when synced cs_n == 1. Any partial word is discarded and bit_cnt is cleared.
- SCK edges while cs_n is high are ignored. Falling edges are ignored.
- Word completion with rx_valid == 0 or (rx_valid && rx_ready): rx_data <= new word and rx_valid <= 1.
- Word completion with rx_valid && !rx_ready: the new word is dropped, rx_data keeps the old word, and overrun <= 1.
- A handshake (rx_valid && rx_ready) with no completion in the same cycle: rx_valid <= 0. rx_data holds its value.
- overrun_clr clears overrun. If the clear and a new overrun occur in the same cycle, set wins.
- Reset (including mid-transfer): rx_data = 0, rx_valid = 0, overrun = 0, busy = 0, state = IDLE, bit_cnt = 0, shreg = 0.

## Timing
- Pin-to-detect latency: a sck rise is detected SYNC_STAGES+1 clk cycles after it reaches the pin.
- The last-bit detect cycle registers the word. rx_valid is high on the following clk edge, so total latency is SYNC_STAGES+2 clk cycles from the final SCK rise.
- busy rises SYNC_STAGES+1 cycles after the cs_n fall and drops SYNC_STAGES+1 cycles after the cs_n rise.
- The consumer may hold rx_ready high permanently. Throughput is then one word per DATA_W SCK periods with no loss.
- MOSI is sampled in the same cycle as the detected edge. Because mosi and sck share the same synchronizer depth, their skew is preserved.

## Structure
- Shared package spi_pkg holds:
  - the default SPI_DATA_W = 8;
  - the FSM state typedef (IDLE, ACTIVE);
  - the SPI mode constant (CPOL=0, CPHA=0), shared with the transmitter.
- Sub-module sync_bit: a SYNC_STAGES-deep flop chain with an async reset value parameter. It is instantiated three times, once each for sck, cs_n and mosi.
- Everything else stays in one module: edge detect, FSM, counter, shift register and output register.

## Test plan
- Single word: cs_n low, shift 8'hA5 MSB first at clk/8 SCK, rx_ready=0. Expect rx_data=8'hA5 and rx_valid=1 at SYNC_STAGES+2 cycles after the 8th rise; busy=1 throughout.
- Back-to-back: send 8'h3C then 8'hC3 under one CS with rx_ready=1. Expect two single-cycle rx_valid pulses with 8'h3C then 8'hC3, and overrun=0.
- Overrun: send 8'h11 then 8'h22 with rx_ready=0. Expect rx_data=8'h11 and overrun=1. Pulse overrun_clr and expect overrun=0.
- Accept-and-complete same cycle: assert rx_ready exactly on the completion cycle of the second word. Expect rx_data to switch to the new word, rx_valid to stay 1, and overrun to stay 0.
- Aborted word: raise cs_n after 5 bits of 8'hFF, then send 8'h81 in a new CS frame. Expect only 8'h81 to be delivered.
- Async reset mid-word: pulse rst after 3 bits. Expect all outputs 0 immediately. A following 8'h5A frame must be received correctly.
